cs2fifoc: RTL and testbench

- Command-packet framer that sits directly upstream of the command FIFO read by the config-register loader.
- Hunts a raw byte stream (UART/USB receiver side) for the 0x55 0xAA header, buffers 9 command bytes and the checksum byte, and verifies the checksum.
- Only a valid packet is burst-written into the FIFO as 12 bytes, then the loader is started with an fs/fd handshake. Bad or stalled packets are dropped and counted, so the loader never sees them.

---
 rtl/cs2fifoc.sv | 206 ++++++++++++++++++++
 tb/tb_cs2fifoc.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs2fifoc.sv
// cs2fifoc: command-packet framer feeding the command FIFO of the config loader.
// Hunts the 0x55 0xAA header in a raw byte stream and buffers the 9 command bytes
// plus the checksum. Only a packet whose checksum matches is burst-written into
// the FIFO as 12 bytes, and then the loader is started with an fs/fd handshake.
// Bad, truncated or stalled packets are dropped and counted in err_cnt.
module cs2fifoc #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int          NCMD    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       fifoc_full,
    output logic       fifoc_txen,
    output logic [7:0] fifoc_txd,
    output logic       fs,
    input  logic       fd,
    output logic       busy,
    output logic [7:0] pkt_cnt,
    output logic [7:0] err_cnt
);

    // Bytes in the forwarded frame: two header bytes, the payload, the checksum
    localparam int         NPKT = NCMD + 3;
    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    typedef enum logic [2:0] {
        HUNT0 = 3'd0,
        HUNT1 = 3'd1,
        PAYL  = 3'd2,
        CHK   = 3'd3,
        WRIT  = 3'd4,
        SEND  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state_reg;
    logic [7:0]  pbuf_reg [NCMD];
    logic [7:0]  sum_reg;
    logic [3:0]  idx_reg;
    logic [3:0]  widx_reg;
    logic [15:0] tcnt_reg;
    logic        fifoc_txen_reg;
    logic [7:0]  fifoc_txd_reg;
    logic        fs_reg;
    logic [7:0]  pkt_cnt_reg;
    logic [7:0]  err_cnt_reg;

    logic        timed_state;
    logic        tmo_hit;
    logic [7:0]  err_cnt_next;
    logic [7:0]  wr_byte;

    assign fifoc_txen = fifoc_txen_reg;
    assign fifoc_txd  = fifoc_txd_reg;
    assign fs         = fs_reg;
    assign pkt_cnt    = pkt_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign busy       = (state_reg == WRIT) || (state_reg == SEND) || (state_reg == DONE);

    // The inter-byte watchdog only runs while a packet is partially received.
    // A byte arriving in the same cycle as expiry takes precedence.
    assign timed_state = (state_reg == HUNT1) || (state_reg == PAYL) || (state_reg == CHK);
    assign tmo_hit     = timed_state && !din_vld && (tcnt_reg == TIMEOUT - 16'd1);

    // Error counter saturates instead of wrapping
    assign err_cnt_next = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;

    // Select the frame byte addressed by the write index: header, payload, checksum
    always_comb begin
        wr_byte = sum_reg;
        if (widx_reg == 4'd0) begin
            wr_byte = HDR0;
        end else if (widx_reg == 4'd1) begin
            wr_byte = HDR1;
        end else if (widx_reg < 4'(NPKT - 1)) begin
            wr_byte = pbuf_reg[widx_reg - 4'd2];
        end
    end

    // Payload storage, one byte register per command slot
    genvar gi;
    generate
        for (gi = 0; gi < NCMD; gi++) begin : g_pbuf
            // Capture the payload byte addressed by the receive index
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pbuf_reg[gi] <= 8'd0;
                end else if ((state_reg == PAYL) && din_vld && (idx_reg == 4'(gi))) begin
                    pbuf_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Framer FSM with registered FIFO, handshake and counter outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= HUNT0;
            sum_reg        <= 8'd0;
            idx_reg        <= 4'd0;
            widx_reg       <= 4'd0;
            tcnt_reg       <= 16'd0;
            fifoc_txen_reg <= 1'b0;
            fifoc_txd_reg  <= 8'd0;
            fs_reg         <= 1'b0;
            pkt_cnt_reg    <= 8'd0;
            err_cnt_reg    <= 8'd0;
        end else begin
            fifoc_txen_reg <= 1'b0;

            // Idle-cycle counter restarts on every received byte
            if (din_vld || !timed_state) begin
                tcnt_reg <= 16'd0;
            end else begin
                tcnt_reg <= tcnt_reg + 16'd1;
            end

            case (state_reg)
                HUNT0: begin
                    if (din_vld && (din == HDR0)) begin
                        state_reg <= HUNT1;
                    end
                end
                HUNT1: begin
                    if (din_vld) begin
                        if (din == HDR1) begin
                            state_reg <= PAYL;
                            idx_reg   <= 4'd0;
                            sum_reg   <= 8'd0;
                        end else if (din != HDR0) begin
                            // A repeated 0x55 may still be the real header start
                            state_reg   <= HUNT0;
                            err_cnt_reg <= err_cnt_next;
                        end
                    end else if (tmo_hit) begin
                        state_reg   <= HUNT0;
                        err_cnt_reg <= err_cnt_next;
                    end
                end
                PAYL: begin
                    if (din_vld) begin
                        sum_reg <= sum_reg + din;
                        if (idx_reg == 4'(NCMD - 1)) begin
                            state_reg <= CHK;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        state_reg   <= HUNT0;
                        err_cnt_reg <= err_cnt_next;
                    end
                end
                CHK: begin
                    if (din_vld) begin
                        if (din == sum_reg) begin
                            state_reg <= WRIT;
                            widx_reg  <= 4'd0;
                        end else begin
                            state_reg   <= HUNT0;
                            err_cnt_reg <= err_cnt_next;
                        end
                    end else if (tmo_hit) begin
                        state_reg   <= HUNT0;
                        err_cnt_reg <= err_cnt_next;
                    end
                end
                WRIT: begin
                    // txd always shows the pending byte; txen only when the FIFO has room
                    fifoc_txd_reg <= wr_byte;
                    if (!fifoc_full) begin
                        fifoc_txen_reg <= 1'b1;
                        if (widx_reg == 4'(NPKT - 1)) begin
                            state_reg <= SEND;
                        end else begin
                            widx_reg <= widx_reg + 4'd1;
                        end
                    end
                end
                SEND: begin
                    if (fd) begin
                        state_reg   <= DONE;
                        fs_reg      <= 1'b0;
                        pkt_cnt_reg <= pkt_cnt_reg + 8'd1;
                    end else begin
                        fs_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Wait for the loader to drop fd before hunting again
                    fs_reg <= 1'b0;
                    if (!fd) begin
                        state_reg <= HUNT0;
                    end
                end
                default: begin
                    state_reg <= HUNT0;
                    fs_reg    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs2fifoc.sv
// tb_cs2fifoc: directed plus randomized bench for the cs2fifoc packet framer.
// A frame-level reference model decides which packets are good and what the
// error/packet counters must read; FIFO writes are compared byte by byte.
module tb_cs2fifoc;

    localparam int TMO  = 20;
    localparam int NPKT = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       fifoc_full;
    logic       fifoc_txen;
    logic [7:0] fifoc_txd;
    logic       fs;
    logic       fd;
    logic       busy;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bytes of the frame being assembled, expected output frame
    logic [7:0] frame [$];
    logic [7:0] exp_pkt [$];
    bit         pkt_ready;
    int         m_err;
    int         m_pkt;

    logic [7:0] pl [9];

    cs2fifoc #(
        .TIMEOUT(16'(TMO)),
        .NCMD   (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .fifoc_full(fifoc_full),
        .fifoc_txen(fifoc_txen),
        .fifoc_txd (fifoc_txd),
        .fs        (fs),
        .fd        (fd),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_bump_err();
        if (m_err < 255) m_err++;
    endfunction

    // An unfinished frame left idle for TMO cycles or more is dropped as an error
    function automatic void model_idle(input int n);
        if (frame.size() != 0 && n >= TMO) begin
            frame.delete();
            m_bump_err();
        end
    endfunction

    // Frame-level parser: the frame length says what the next byte must be
    function automatic void model_byte(input logic [7:0] b, input int gap);
        logic [7:0] s;
        model_idle(gap);
        case (frame.size())
            0: if (b == 8'h55) frame.push_back(b);
            1: begin
                if (b == 8'hAA) frame.push_back(b);
                else if (b != 8'h55) begin
                    frame.delete();
                    m_bump_err();
                end
            end
            11: begin
                s = 8'h00;
                for (int i = 2; i < 11; i++) s = s + frame[i];
                if (b == s) begin
                    frame.push_back(b);
                    exp_pkt   = frame;
                    pkt_ready = 1'b1;
                end else begin
                    m_bump_err();
                end
                frame.delete();
            end
            default: frame.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] psum(input logic [7:0] p [9]);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 9; i++) s = s + p[i];
        return s;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [7:0] p [9], input logic [7:0] ck, input int i);
        if (i == 0) return 8'h55;
        if (i == 1) return 8'hAA;
        if (i < 11) return p[i-2];
        return ck;
    endfunction

    // Idle for gap cycles, then present one byte for one cycle
    task automatic send_byte(input logic [7:0] b, input int gap, input bit use_model);
        repeat (gap) @(negedge clk);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        if (use_model) model_byte(b, gap);
    endtask

    // Send the first nbytes of a frame; long_at selects the byte preceded by a TMO-1 gap
    task automatic send_frame(input logic [7:0] p [9], input logic [7:0] ck, input int nbytes,
                              input int maxgap, input int long_at);
        int g;
        for (int i = 0; i < nbytes; i++) begin
            if (i == long_at) g = TMO - 1;
            else if (i == 0) g = 0;
            else g = int'($urandom_range(maxgap, 0));
            send_byte(frame_byte(p, ck, i), g, 1'b1);
        end
    endtask

    task automatic idle_chk(input int n, input string tag);
        int nt;
        int nf;
        nt = 0;
        nf = 0;
        repeat (n) begin
            @(negedge clk);
            if (fifoc_txen) nt++;
            if (fs) nf++;
        end
        check({tag, "_txen"}, nt, 0);
        check({tag, "_fs"}, nf, 0);
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_err"}, 32'(err_cnt), m_err);
        check({tag, "_pkt"}, 32'(pkt_cnt), m_pkt % 256);
    endtask

    // Gather the 12 FIFO writes, optionally holding fifoc_full high for bp_len
    // cycles right after write number bp_after
    task automatic collect_pkt(input int bp_after, input int bp_len, input string tag);
        int nw;
        int cyc;
        int last;
        int bp_left;
        bit bp_done;
        nw = 0; cyc = 0; last = 0; bp_left = 0; bp_done = 1'b0;
        while (nw < NPKT && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (fifoc_txen) begin
                check({tag, "_nofull"}, 32'(fifoc_full), 0);
                check({tag, "_byte"}, 32'(fifoc_txd), 32'(exp_pkt[nw]));
                check({tag, "_fs_low"}, 32'(fs), 0);
                if (nw == 0) check({tag, "_busy"}, 32'(busy), 1);
                if (nw > 0)
                    check({tag, "_gap"}, cyc - last, (bp_len > 0 && nw == bp_after) ? bp_len + 1 : 1);
                last = cyc;
                nw++;
            end
            if (bp_left > 0) begin
                bp_left--;
                if (bp_left == 0) fifoc_full = 1'b0;
            end else if (bp_len > 0 && !bp_done && nw == bp_after) begin
                fifoc_full = 1'b1;
                bp_left    = bp_len;
                bp_done    = 1'b1;
            end
        end
        fifoc_full = 1'b0;
        check({tag, "_count"}, nw, NPKT);
        @(negedge clk);
        check({tag, "_fs_high"}, 32'(fs), 1);
    endtask

    task automatic handshake(input string tag);
        repeat ($urandom_range(3, 0)) begin
            @(negedge clk);
            check({tag, "_fs_hold"}, 32'(fs), 1);
        end
        fd = 1'b1;
        @(negedge clk);
        m_pkt++;
        check({tag, "_fs_drop"}, 32'(fs), 0);
        check({tag, "_pkt"}, 32'(pkt_cnt), m_pkt % 256);
        check({tag, "_done_busy"}, 32'(busy), 1);
        fd = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        pkt_ready = 1'b0;
    endtask

    initial begin
        int         kind;
        int         k;
        logic [7:0] b;

        rst = 1'b0; din = 8'h00; din_vld = 1'b0; fifoc_full = 1'b0; fd = 1'b0;
        pkt_ready = 1'b0; m_err = 0; m_pkt = 0;

        // 1: reset values, then a quiet stream produces nothing
        repeat (3) @(negedge clk);
        check("rst_txen", 32'(fifoc_txen), 0);
        check("rst_txd", 32'(fifoc_txd), 0);
        check("rst_fs", 32'(fs), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pkt", 32'(pkt_cnt), 0);
        check("rst_err", 32'(err_cnt), 0);
        rst = 1'b1;
        idle_chk(100, "idle");

        // 2: known good packet, back-to-back bytes
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_frame(pl, 8'h2D, 12, 0, -1);
        collect_pkt(0, 0, "good");
        handshake("good");
        check("good_pkt1", 32'(pkt_cnt), 1);
        check("good_err0", 32'(err_cnt), 0);
        $display("txn directed good pkt_cnt=%0d err_cnt=%0d", pkt_cnt, err_cnt);

        // 3: checksum failure, then resync on 55 55 AA with a zero-sum payload
        send_frame(pl, 8'h2E, 12, 0, -1);
        idle_chk(5, "badsum");
        check("badsum_err1", 32'(err_cnt), 1);
        pl = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_byte(8'h55, 0, 1'b1);
        send_frame(pl, 8'h00, 12, 0, -1);
        collect_pkt(0, 0, "resync");
        handshake("resync");
        check_cnt("resync");
        $display("txn directed badsum+resync pkt_cnt=%0d err_cnt=%0d", pkt_cnt, err_cnt);

        // 4: back-pressure for 5 cycles after the 3rd write
        for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
        send_frame(pl, psum(pl), 12, 2, -1);
        collect_pkt(3, 5, "bp");
        handshake("bp");
        check_cnt("bp");
        $display("txn directed backpressure pkt_cnt=%0d err_cnt=%0d", pkt_cnt, err_cnt);

        // 5: timeout boundary: TMO-1 idle cycles keep the packet, TMO drops it
        pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
        send_frame(pl, psum(pl), 4, 0, -1);
        idle_chk(TMO - 1, "tmo_pre");
        check("tmo_pre_err", 32'(err_cnt), m_err);
        idle_chk(1, "tmo_hit");
        model_idle(TMO);
        check("tmo_err", 32'(err_cnt), m_err);
        check("tmo_busy", 32'(busy), 0);
        send_frame(pl, psum(pl), 12, 1, 6);
        collect_pkt(0, 0, "tmo_edge");
        handshake("tmo_edge");
        check_cnt("tmo_edge");
        $display("txn directed timeout pkt_cnt=%0d err_cnt=%0d", pkt_cnt, err_cnt);

        // 6: bytes during SEND are ignored, then an asynchronous reset mid-handshake
        for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
        send_frame(pl, psum(pl), 12, 1, -1);
        collect_pkt(0, 0, "arst");
        send_byte(8'h55, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h55, 1, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        check("send_ign_err", 32'(err_cnt), m_err);
        check("send_ign_fs", 32'(fs), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_fs", 32'(fs), 0);
        check("arst_pkt", 32'(pkt_cnt), 0);
        check("arst_err", 32'(err_cnt), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_txd", 32'(fifoc_txd), 0);
        m_err = 0; m_pkt = 0; frame.delete(); pkt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
        send_frame(pl, psum(pl), 12, 3, -1);
        collect_pkt(0, 0, "post_rst");
        handshake("post_rst");
        check_cnt("post_rst");
        $display("txn directed async-reset pkt_cnt=%0d err_cnt=%0d", pkt_cnt, err_cnt);

        // Randomized mix of good, corrupt, truncated and noisy packets
        for (int p = 0; p < 24; p++) begin
            kind = int'($urandom_range(4, 0));
            for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
            case (kind)
                0, 4: begin
                    if (kind == 4) begin
                        repeat ($urandom_range(4, 1)) begin
                            b = 8'($urandom);
                            if (b == 8'h55) b = 8'h56;
                            send_byte(b, int'($urandom_range(3, 0)), 1'b1);
                        end
                    end
                    send_frame(pl, psum(pl), 12, int'($urandom_range(4, 0)),
                               ($urandom_range(3, 0) == 0) ? int'($urandom_range(11, 1)) : -1);
                end
                1: send_frame(pl, psum(pl) + 8'($urandom_range(255, 1)), 12, 2, -1);
                2: begin
                    send_byte(8'h55, 0, 1'b1);
                    b = 8'($urandom);
                    if (b == 8'h55 || b == 8'hAA) b = 8'h00;
                    send_byte(b, int'($urandom_range(3, 0)), 1'b1);
                end
                default: begin
                    k = int'($urandom_range(11, 1));
                    send_frame(pl, psum(pl), k, 2, -1);
                    k = TMO + int'($urandom_range(3, 0));
                    idle_chk(k, "rnd_tmo");
                    model_idle(k);
                end
            endcase
            if (pkt_ready) begin
                collect_pkt(int'($urandom_range(11, 1)), int'($urandom_range(4, 0)), "rnd");
                handshake("rnd");
            end else begin
                idle_chk(3, "rnd_drop");
            end
            check_cnt("rnd");
            $display("txn random %0d kind=%0d pkt_cnt=%0d err_cnt=%0d", p, kind, pkt_cnt, err_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
